// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode/forwarding side and the ID/EX stage.
// master drives the ID fields and forwarding sources, slave is the stage itself.
interface id_ex_stage_if;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [31:0] id_imm_ext;
    logic [4:0]  id_alu_ctl;
    logic        id_sign;
    logic        id_alusrc1;
    logic        id_alusrc2;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_reg_write;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        flush;
    logic        hold;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [4:0]  alu_ctl;
    logic        alu_sign;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_rd;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        id_stall;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_shamt, id_imm_ext,
               id_alu_ctl, id_sign, id_alusrc1, id_alusrc2, id_mem_read, id_mem_write,
               id_reg_write, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
               memwb_rd, memwb_result, flush, hold,
        input  alu_in1, alu_in2, alu_ctl, alu_sign, ex_rt_data, ex_rd, ex_valid, ex_mem_read,
               ex_mem_write, ex_reg_write, id_stall
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_rs, id_rt, id_rd, id_shamt, id_imm_ext,
               id_alu_ctl, id_sign, id_alusrc1, id_alusrc2, id_mem_read, id_mem_write,
               id_reg_write, exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write,
               memwb_rd, memwb_result, flush, hold,
        output alu_in1, alu_in2, alu_ctl, alu_sign, ex_rt_data, ex_rd, ex_valid, ex_mem_read,
               ex_mem_write, ex_reg_write, id_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall, flush and hold.
// Define ID_EX_FORWARD_EN to enable the forwarding muxes; otherwise any RAW against EX or EX/MEM stalls.
module id_ex_stage (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm_ext;
        logic [4:0]  alu_ctl;
        logic        sign;
        logic        alusrc1;
        logic        alusrc2;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } ex_reg_t;

    ex_reg_t     ex_q;
    ex_reg_t     id_fields;
    logic        load_use;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    function automatic logic raw_hit(logic w, logic [4:0] r, logic [4:0] rs, logic [4:0] rt);
        return w & (r != 5'd0) & ((r == rs) | (r == rt));
    endfunction

    always_comb begin
        id_fields           = '0;
        id_fields.valid     = bus.id_valid;
        id_fields.rs        = bus.id_rs;
        id_fields.rt        = bus.id_rt;
        id_fields.rd        = bus.id_rd;
        id_fields.shamt     = bus.id_shamt;
        id_fields.rs_data   = bus.id_rs_data;
        id_fields.rt_data   = bus.id_rt_data;
        id_fields.imm_ext   = bus.id_imm_ext;
        id_fields.alu_ctl   = bus.id_alu_ctl;
        id_fields.sign      = bus.id_sign;
        id_fields.alusrc1   = bus.id_alusrc1;
        id_fields.alusrc2   = bus.id_alusrc2;
        id_fields.mem_read  = bus.id_mem_read;
        id_fields.mem_write = bus.id_mem_write;
        id_fields.reg_write = bus.id_reg_write;
    end

`ifdef ID_EX_FORWARD_EN
    assign load_use = bus.id_valid &
                      raw_hit(ex_q.valid & ex_q.mem_read, ex_q.rd, bus.id_rs, bus.id_rt);

    // Later assignment wins, so EX/MEM overrides MEM/WB.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
        if (raw_hit(bus.memwb_reg_write, bus.memwb_rd, ex_q.rs, 5'd0)) fwd_rs = bus.memwb_result;
        if (raw_hit(bus.memwb_reg_write, bus.memwb_rd, ex_q.rt, 5'd0)) fwd_rt = bus.memwb_result;
        if (raw_hit(bus.exmem_reg_write, bus.exmem_rd, ex_q.rs, 5'd0)) fwd_rs = bus.exmem_result;
        if (raw_hit(bus.exmem_reg_write, bus.exmem_rd, ex_q.rt, 5'd0)) fwd_rt = bus.exmem_result;
    end
`else
    assign load_use = bus.id_valid &
                      (raw_hit(ex_q.reg_write & ex_q.valid, ex_q.rd, bus.id_rs, bus.id_rt) |
                       raw_hit(bus.exmem_reg_write, bus.exmem_rd, bus.id_rs, bus.id_rt));
    assign fwd_rs   = ex_q.rs_data;
    assign fwd_rt   = ex_q.rt_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else if (bus.flush) begin
            ex_q <= '0;
        end else if (bus.hold) begin
            ex_q <= ex_q;
        end else if (load_use) begin
            ex_q <= '0;
        end else begin
            ex_q <= id_fields;
        end
    end

    assign bus.alu_in1      = ex_q.alusrc1 ? {27'd0, ex_q.shamt} : fwd_rs;
    assign bus.alu_in2      = ex_q.alusrc2 ? ex_q.imm_ext : fwd_rt;
    assign bus.ex_rt_data   = fwd_rt;
    assign bus.alu_ctl      = ex_q.alu_ctl;
    assign bus.alu_sign     = ex_q.sign;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_reg_write = ex_q.reg_write;
    // A flush redirects upstream, so it must not also be told to stall.
    assign bus.id_stall     = ~bus.flush & (bus.hold | load_use);
endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if bus ();
    id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    // Model: the instruction currently in EX, as a plain record.
    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd, shamt, ctl;
        bit [31:0] rs_data, rt_data, imm;
        bit        sign, src1, src2, mr, mw, rw;
    } inst_t;

    inst_t ex_m;
    inst_t bubble;
    int    errors = 0;
    int    checks = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic inst_t id_inst();
        inst_t i;
        i.valid = bus.id_valid;   i.rs = bus.id_rs;           i.rt = bus.id_rt;
        i.rd = bus.id_rd;         i.shamt = bus.id_shamt;     i.ctl = bus.id_alu_ctl;
        i.rs_data = bus.id_rs_data; i.rt_data = bus.id_rt_data; i.imm = bus.id_imm_ext;
        i.sign = bus.id_sign;     i.src1 = bus.id_alusrc1;    i.src2 = bus.id_alusrc2;
        i.mr = bus.id_mem_read;   i.mw = bus.id_mem_write;    i.rw = bus.id_reg_write;
        return i;
    endfunction

    // Does a writer (enable w, dest r) produce a value the ID instruction reads?
    function automatic bit reads(bit w, bit [4:0] r);
        return w && r != 0 && (r == bus.id_rs || r == bus.id_rt);
    endfunction

    function automatic bit hazard();
        if (!bus.id_valid) return 0;
`ifdef ID_EX_FORWARD_EN
        return reads(ex_m.valid && ex_m.mr, ex_m.rd);
`else
        return reads(ex_m.valid && ex_m.rw, ex_m.rd) || reads(bus.exmem_reg_write, bus.exmem_rd);
`endif
    endfunction

    function automatic bit [31:0] operand(bit [4:0] r, bit [31:0] raw);
`ifdef ID_EX_FORWARD_EN
        if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == r) return bus.memwb_result;
`endif
        return raw;
    endfunction

    task automatic check_outputs(string tag);
        bit [31:0] rt_val;
        rt_val = operand(ex_m.rt, ex_m.rt_data);
        check({tag, ".alu_in1"}, bus.alu_in1,
              ex_m.src1 ? {27'd0, ex_m.shamt} : operand(ex_m.rs, ex_m.rs_data));
        check({tag, ".alu_in2"}, bus.alu_in2, ex_m.src2 ? ex_m.imm : rt_val);
        check({tag, ".rt_data"}, bus.ex_rt_data, rt_val);
        check({tag, ".alu_ctl"}, {27'd0, bus.alu_ctl}, {27'd0, ex_m.ctl});
        check({tag, ".sign"}, {31'd0, bus.alu_sign}, {31'd0, ex_m.sign});
        check({tag, ".ex_rd"}, {27'd0, bus.ex_rd}, {27'd0, ex_m.rd});
        check({tag, ".ctrl"},
              {28'd0, bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write},
              {28'd0, ex_m.valid, ex_m.mr, ex_m.mw, ex_m.rw});
    endtask

    // Called just after a negedge with inputs driven; checks, then advances one clock.
    task automatic step(string tag);
        inst_t nxt;
        bit    lu;
        #1;
        lu = hazard();
        check({tag, ".stall"}, {31'd0, bus.id_stall},
              {31'd0, !bus.flush && (bus.hold || lu)});
        check_outputs(tag);
        if (bus.flush)     nxt = bubble;
        else if (bus.hold) nxt = ex_m;
        else if (lu)       nxt = bubble;
        else               nxt = id_inst();
        @(posedge clk);
        ex_m = nxt;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_rs = 0; bus.id_rt = 0;
        bus.id_rd = 0; bus.id_shamt = 0; bus.id_imm_ext = 0; bus.id_alu_ctl = 0; bus.id_sign = 0;
        bus.id_alusrc1 = 0; bus.id_alusrc2 = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.id_reg_write = 0; bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
        bus.flush = 0; bus.hold = 0;
    endtask

    task automatic drive_random();
        bus.id_valid = $urandom_range(0, 3) != 0;
        bus.id_rs = 5'($urandom_range(0, 3));       bus.id_rt = 5'($urandom_range(0, 3));
        bus.id_rd = 5'($urandom_range(0, 3));       bus.id_shamt = 5'($urandom);
        bus.id_rs_data = $urandom;  bus.id_rt_data = $urandom;  bus.id_imm_ext = $urandom;
        bus.id_alu_ctl = 5'($urandom); bus.id_sign = 1'($urandom);
        bus.id_alusrc1 = $urandom_range(0, 3) == 0; bus.id_alusrc2 = 1'($urandom);
        bus.id_mem_read = $urandom_range(0, 2) == 0; bus.id_mem_write = $urandom_range(0, 3) == 0;
        bus.id_reg_write = 1'($urandom);
        bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 3));
        bus.exmem_result = $urandom;
        bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 3));
        bus.memwb_result = $urandom;
        bus.flush = $urandom_range(0, 7) == 0;
        bus.hold = $urandom_range(0, 5) == 0;
    endtask

    task automatic check_reset_zero(string tag);
        check({tag, ".outs"}, bus.alu_in1 | bus.alu_in2 | bus.ex_rt_data, 32'd0);
        check({tag, ".fields"},
              {20'd0, bus.alu_ctl, bus.alu_sign, bus.ex_rd, bus.ex_valid},
              32'd0);
        check({tag, ".ctrl"}, {29'd0, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write}, 32'd0);
    endtask

    initial begin
        bubble = '{default: 0};
        ex_m   = bubble;
        clear_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_zero("por");
        check("por.stall", {31'd0, bus.id_stall}, 32'd0);
        reset = 0;
        @(negedge clk);

        // EX/MEM over MEM/WB forwarding
        bus.id_valid = 1; bus.id_rs = 3; bus.id_rt = 4; bus.id_rd = 5; bus.id_rs_data = 32'h11;
        bus.id_reg_write = 1;
        step("fwd.load");
        bus.hold = 1;
        bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 32'hAAAA_0000;
        bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_result = 32'h5;
        step("fwd.exmem");
        bus.exmem_rd = 0;
        step("fwd.memwb");

        // load-use: lw r8 then a consumer of r8
        clear_inputs();
        bus.id_valid = 1; bus.id_rd = 8; bus.id_mem_read = 1; bus.id_reg_write = 1;
        step("lu.lw");
        bus.id_mem_read = 0; bus.id_rs = 8; bus.id_rt = 2; bus.id_rd = 9; bus.id_rs_data = 32'h1;
        #1;
        check("lu.stall_hi", {31'd0, bus.id_stall}, 32'd1);
        step("lu.stall");
        bus.exmem_reg_write = 1; bus.exmem_rd = 8; bus.exmem_result = 32'h1234_5678;
        step("lu.proceed");
        clear_inputs();
        bus.exmem_reg_write = 1; bus.exmem_rd = 8; bus.exmem_result = 32'h1234_5678;
        step("lu.fwd");

        // shift amount as operand 1
        clear_inputs();
        bus.id_valid = 1; bus.id_alusrc1 = 1; bus.id_shamt = 7; bus.id_alu_ctl = 5'b10000;
        bus.id_rt = 6; bus.id_rt_data = 32'h1; bus.id_rs_data = 32'hFFFF;
        step("shift.load");
        clear_inputs();
        step("shift.out");

        // flush+hold, then hold alone
        bus.id_valid = 1; bus.id_rd = 4; bus.id_reg_write = 1;
        step("fh.load");
        bus.flush = 1; bus.hold = 1;
        step("fh.both");
        bus.flush = 0;
        step("fh.hold");
        bus.hold = 0;
        step("fh.release");

        // store: immediate operand, forwarded store data
        clear_inputs();
        bus.id_valid = 1; bus.id_alusrc2 = 1; bus.id_imm_ext = 32'h10; bus.id_rt = 9;
        bus.id_mem_write = 1; bus.id_rt_data = 32'h3;
        step("sw.load");
        clear_inputs();
        bus.memwb_reg_write = 1; bus.memwb_rd = 9; bus.memwb_result = 32'hDEAD;
        step("sw.out");

        for (int n = 0; n < 600; n++) begin
            drive_random();
            if ($urandom_range(0, 59) == 0) begin
                #3;
                reset = 1;
                ex_m = bubble;
                #1;
                check_reset_zero("rnd.reset");
                @(negedge clk);
                reset = 0;
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
